// File: rtl/ctx_pkg.sv
// Shared definitions for the context-write scheduler: FSM encoding, FIFO entry
// layout and counter limits.
package ctx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WAIT  = 2'd3
  } ctx_state_t;

  localparam int CTX_ADDR_W   = 24;
  localparam int CTX_DATA_W   = 16;
  localparam int CTX_WR_W     = 41;
  localparam int CTX_WORD_BIT = 0;
  localparam int CTX_DATA_LSB = 1;
  localparam int CTX_ADDR_LSB = 17;

  localparam logic [7:0] OVF_SAT = 8'hFF;

  function automatic logic [CTX_WR_W-1:0] ctx_pack(input logic [CTX_ADDR_W-1:0] addr,
                                                   input logic [CTX_DATA_W-1:0] data,
                                                   input logic              word);
    return {addr, data, word};
  endfunction

endpackage

// File: rtl/ctx_wr_fifo.sv
// Synchronous snoop-write FIFO; a push into a full FIFO is still accepted when
// the head is popped on the same edge.
module ctx_wr_fifo
  import ctx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [CTX_WR_W-1:0]   wdata,
  output logic [CTX_WR_W-1:0]   head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [CTX_WR_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clkin) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ctx_wr_sched.sv
// Arbitrates buffered snoop writes against MCU restore writes onto the shared
// SRAM write port, with fixed 4-cycle request spacing and bounded MCU starvation.
module ctx_wr_sched
  import ctx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                clkin,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                snoop_req,
  input  logic [23:0]         snoop_addr,
  input  logic [15:0]         snoop_data,
  input  logic                snoop_word,
  input  logic                mcu_valid,
  output logic                mcu_ready,
  input  logic [23:0]         mcu_addr,
  input  logic [15:0]         mcu_data,
  input  logic                mcu_word,
  output logic                BUS_WRQ,
  input  logic                BUS_RDY,
  output logic [23:0]         ROM_ADDR,
  output logic [15:0]         ROM_DATA,
  output logic                ROM_WORD_ENABLE,
  output logic [DEPTH_LOG2:0] fifo_level,
  output logic [7:0]          overflow_cnt,
  output logic                busy
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  ctx_state_t            state;
  ctx_state_t            state_nxt;
  logic [CTX_WR_W-1:0]   fifo_wdata;
  logic [CTX_WR_W-1:0]   fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  snoop_grant;
  logic                  mcu_grant;
  logic [2:0]            starve_cnt;

  assign push       = snoop_req & enable;
  assign fifo_wdata = ctx_pack(snoop_addr, snoop_data, snoop_word);
  assign busy       = ~fifo_empty | (state != ST_IDLE);

  ctx_wr_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clkin  (clkin),
    .reset_n(reset_n),
    .push   (push),
    .pop    (snoop_grant),
    .wdata  (fifo_wdata),
    .head   (fifo_head),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants are gated by reset so no accept strobe escapes during a reset cycle.
  always_comb begin
    state_nxt   = state;
    BUS_WRQ     = 1'b0;
    mcu_ready   = 1'b0;
    snoop_grant = 1'b0;
    mcu_grant   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reset_n && BUS_RDY) begin
          if (!fifo_empty && (starve_cnt < STARVE_LIM || !mcu_valid)) begin
            snoop_grant = 1'b1;
          end else if (mcu_valid) begin
            mcu_grant = 1'b1;
          end
        end
        mcu_ready = mcu_grant;
        if (snoop_grant || mcu_grant) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        BUS_WRQ   = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (BUS_RDY) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!mcu_valid || mcu_grant) begin
      starve_cnt <= '0;
    end else if (snoop_grant) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // A full FIFO only drops the entry if the head is not leaving on the same edge.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      overflow_cnt <= '0;
    end else if (push && fifo_full && !snoop_grant && overflow_cnt != OVF_SAT) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      ROM_ADDR        <= '0;
      ROM_DATA        <= '0;
      ROM_WORD_ENABLE <= 1'b0;
    end else if (snoop_grant) begin
      ROM_ADDR        <= fifo_head[CTX_ADDR_LSB +: CTX_ADDR_W];
      ROM_DATA        <= fifo_head[CTX_DATA_LSB +: CTX_DATA_W];
      ROM_WORD_ENABLE <= fifo_head[CTX_WORD_BIT];
    end else if (mcu_grant) begin
      ROM_ADDR        <= mcu_addr;
      ROM_DATA        <= mcu_data;
      ROM_WORD_ENABLE <= mcu_word;
    end
  end

endmodule

// File: tb/tb_ctx_wr_sched.sv
// Scoreboard bench for ctx_wr_sched: expected bus writes are queued as stimulus
// is driven and compared whenever BUS_WRQ is seen.
module tb_ctx_wr_sched;

  logic        clkin = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        snoop_req;
  logic [23:0] snoop_addr;
  logic [15:0] snoop_data;
  logic        snoop_word;
  logic        mcu_valid;
  logic        mcu_ready;
  logic [23:0] mcu_addr;
  logic [15:0] mcu_data;
  logic        mcu_word;
  logic        BUS_WRQ;
  logic        BUS_RDY;
  logic [23:0] ROM_ADDR;
  logic [15:0] ROM_DATA;
  logic        ROM_WORD_ENABLE;
  logic [3:0]  fifo_level;
  logic [7:0]  overflow_cnt;
  logic        busy;

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
    logic        w;
  } wr_t;

  wr_t expq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  wrq_count = 0;
  int  last_wrq_cyc = -1;
  int  gap_from = 0;
  bit  gap_check = 1'b0;
  int  rdy_pulses = 0;

  ctx_wr_sched #(.DEPTH_LOG2(3), .STARVE_MAX(4)) dut (
    .clkin          (clkin),
    .reset_n        (reset_n),
    .enable         (enable),
    .snoop_req      (snoop_req),
    .snoop_addr     (snoop_addr),
    .snoop_data     (snoop_data),
    .snoop_word     (snoop_word),
    .mcu_valid      (mcu_valid),
    .mcu_ready      (mcu_ready),
    .mcu_addr       (mcu_addr),
    .mcu_data       (mcu_data),
    .mcu_word       (mcu_word),
    .BUS_WRQ        (BUS_WRQ),
    .BUS_RDY        (BUS_RDY),
    .ROM_ADDR       (ROM_ADDR),
    .ROM_DATA       (ROM_DATA),
    .ROM_WORD_ENABLE(ROM_WORD_ENABLE),
    .fifo_level     (fifo_level),
    .overflow_cnt   (overflow_cnt),
    .busy           (busy)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Every bus request must match the oldest expected write, in order.
  always @(negedge clkin) begin
    if (BUS_WRQ === 1'b1) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_wrq", 64'(BUS_WRQ), 64'd0);
      end else begin
        wr_t e;
        e = expq.pop_front();
        checkOutput("wr_addr", 64'(ROM_ADDR), 64'(e.a));
        checkOutput("wr_data", 64'(ROM_DATA), 64'(e.d));
        checkOutput("wr_word", 64'(ROM_WORD_ENABLE), 64'(e.w));
      end
      if (gap_check && last_wrq_cyc >= gap_from) begin
        checkOutput("wrq_gap", 64'(cyc - last_wrq_cyc), 64'd4);
      end
      last_wrq_cyc = cyc;
      wrq_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic expectWr(input logic [23:0] a, input logic [15:0] d, input logic w);
    wr_t e;
    e.a = a;
    e.d = d;
    e.w = w;
    expq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [23:0] a, input logic [15:0] d, input logic w,
                               input bit accept);
    snoop_addr = a;
    snoop_data = d;
    snoop_word = w;
    snoop_req  = 1'b1;
    if (accept) expectWr(a, d, w);
    tick(1);
    snoop_req = 1'b0;
  endtask

  task automatic waitWrq(input int target, input int budget);
    int n;
    bit drop;
    n = 0;
    while (wrq_count < target && n < budget) begin
      drop = 1'b0;
      @(negedge clkin);
      if (mcu_ready === 1'b1) begin
        rdy_pulses++;
        drop = 1'b1;
      end
      tick(1);
      if (drop) mcu_valid = 1'b0;
      n++;
    end
    if (wrq_count < target) checkOutput("wrq_timeout", 64'(wrq_count), 64'(target));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wrq"}, 64'(BUS_WRQ), 64'd0);
    checkOutput({tag, "_addr"}, 64'(ROM_ADDR), 64'd0);
    checkOutput({tag, "_data"}, 64'(ROM_DATA), 64'd0);
    checkOutput({tag, "_word"}, 64'(ROM_WORD_ENABLE), 64'd0);
    checkOutput({tag, "_ready"}, 64'(mcu_ready), 64'd0);
    checkOutput({tag, "_level"}, 64'(fifo_level), 64'd0);
    checkOutput({tag, "_ovf"}, 64'(overflow_cnt), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int c, r, start, changed;
    reset_n    = 1'b0;
    enable     = 1'b1;
    snoop_req  = 1'b0;
    snoop_addr = '0;
    snoop_data = '0;
    snoop_word = 1'b0;
    mcu_valid  = 1'b0;
    mcu_addr   = '0;
    mcu_data   = '0;
    mcu_word   = 1'b0;
    BUS_RDY    = 1'b1;
    tick(2);
    checkResetState("por");
    reset_n = 1'b1;
    tick(2);

    $display("[TB] single snoop byte write");
    start = wrq_count;
    c = cyc;
    applyStimulus(24'hF50012, 16'h00AB, 1'b0, 1'b1);
    waitWrq(start + 1, 10);
    checkOutput("single_lat", 64'(last_wrq_cyc), 64'(c + 2));
    tick(6);
    checkOutput("single_once", 64'(wrq_count), 64'(start + 1));
    checkOutput("single_hold_addr", 64'(ROM_ADDR), 64'hF50012);
    checkOutput("single_hold_data", 64'(ROM_DATA), 64'h00AB);
    checkOutput("single_hold_word", 64'(ROM_WORD_ENABLE), 64'd0);
    checkOutput("single_idle_busy", 64'(busy), 64'd0);

    $display("[TB] snoop ignored when disabled");
    enable = 1'b0;
    applyStimulus(24'h123456, 16'h7777, 1'b1, 1'b0);
    checkOutput("disabled_level", 64'(fifo_level), 64'd0);
    enable = 1'b1;
    tick(4);
    checkOutput("disabled_ovf", 64'(overflow_cnt), 64'd0);

    $display("[TB] back-pressure in WAIT");
    start = wrq_count;
    applyStimulus(24'hA00001, 16'h1234, 1'b1, 1'b1);
    tick(1);
    BUS_RDY = 1'b0;
    changed = 0;
    for (int i = 0; i < 22; i++) begin
      if (i == 6) applyStimulus(24'hA00002, 16'h5678, 1'b0, 1'b1);
      else tick(1);
      if (ROM_ADDR !== 24'hA00001 || ROM_DATA !== 16'h1234 || ROM_WORD_ENABLE !== 1'b1)
        changed++;
    end
    checkOutput("bp_rom_stable", 64'(changed), 64'd0);
    checkOutput("bp_busy", 64'(busy), 64'd1);
    checkOutput("bp_one_wrq", 64'(wrq_count), 64'(start + 1));
    checkOutput("bp_level", 64'(fifo_level), 64'd1);
    r = cyc;
    BUS_RDY = 1'b1;
    waitWrq(start + 2, 10);
    checkOutput("bp_resume_lat", 64'(last_wrq_cyc), 64'(r + 2));

    $display("[TB] reset during WAIT");
    BUS_RDY = 1'b0;
    tick(2);
    reset_n = 1'b0;
    tick(2);
    checkResetState("midrst");
    reset_n = 1'b1;
    BUS_RDY = 1'b1;
    start = wrq_count;
    tick(10);
    checkOutput("midrst_no_wrq", 64'(wrq_count), 64'(start));

    $display("[TB] overflow and ordered drain");
    BUS_RDY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(24'h100000 + 24'(i), 16'h1000 + 16'(i), i[0], i < 8);
    end
    checkOutput("ovf_level", 64'(fifo_level), 64'd8);
    checkOutput("ovf_cnt", 64'(overflow_cnt), 64'd2);
    gap_from = cyc;
    gap_check = 1'b1;
    BUS_RDY = 1'b1;
    waitWrq(wrq_count + 8, 60);
    tick(2);
    checkOutput("ovf_drained", 64'(fifo_level), 64'd0);
    gap_check = 1'b0;

    $display("[TB] MCU starvation bound");
    BUS_RDY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(24'h200000 + 24'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
    end
    for (int i = 0; i < 4; i++) expectWr(24'h200000 + 24'(i), 16'h2000 + 16'(i), 1'b1);
    expectWr(24'h7E0040, 16'hBEEF, 1'b1);
    for (int i = 4; i < 8; i++) expectWr(24'h200000 + 24'(i), 16'h2000 + 16'(i), 1'b1);
    mcu_addr  = 24'h7E0040;
    mcu_data  = 16'hBEEF;
    mcu_word  = 1'b1;
    mcu_valid = 1'b1;
    tick(2);
    checkOutput("mcu_wait_rdy_low", 64'(mcu_ready), 64'd0);
    rdy_pulses = 0;
    gap_from = cyc;
    gap_check = 1'b1;
    BUS_RDY = 1'b1;
    waitWrq(wrq_count + 9, 80);
    checkOutput("mcu_ready_pulses", 64'(rdy_pulses), 64'd1);
    checkOutput("starve_sb_empty", 64'(expq.size()), 64'd0);
    gap_check = 1'b0;
    tick(4);

    $display("[TB] push and pop while full");
    BUS_RDY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(24'h300000 + 24'(i), 16'h3000 + 16'(i), i[0], 1'b1);
    end
    checkOutput("pp_full_level", 64'(fifo_level), 64'd8);
    BUS_RDY = 1'b1;
    applyStimulus(24'h3000FF, 16'h30FF, 1'b1, 1'b1);
    checkOutput("pp_level", 64'(fifo_level), 64'd8);
    checkOutput("pp_ovf", 64'(overflow_cnt), 64'd2);
    gap_from = cyc;
    gap_check = 1'b1;
    waitWrq(wrq_count + 9, 80);
    tick(2);
    checkOutput("pp_drained", 64'(fifo_level), 64'd0);
    checkOutput("pp_busy", 64'(busy), 64'd0);
    gap_check = 1'b0;

    checkOutput("sb_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
